// File: rtl/ides4_sc.sv
// ides4_sc: single-clock 1:4 input deserializer with bit-slip.
// Serial bits on D are gathered into 4-bit words on Q0..Q3 (oldest bit in Q0),
// with a one-cycle VALID strobe following each word load. A rising edge on
// CALIB freezes the word-phase counter for one cycle, moving the word boundary
// one bit later.
module ides4_sc #(
  parameter logic INIT = 1'b0
) (
  input  logic CLK,
  input  logic RESET,
  input  logic D,
  input  logic CALIB,
  output logic Q0,
  output logic Q1,
  output logic Q2,
  output logic Q3,
  output logic VALID
);

  localparam int WORD_W = 4;

  // sh_r[0] holds the oldest buffered bit, sh_r[WORD_W-2] the newest.
  logic [WORD_W-2:0] sh_r;
  logic [1:0]        cnt_r;
  logic              calib_q_r;
  logic [WORD_W-1:0] word_r;
  logic              valid_r;

  logic              slip_s;
  logic              load_s;
  logic [1:0]        cnt_next_s;

  // Slip on a CALIB rising edge; load at the last phase unless slipping.
  always_comb begin
    slip_s     = 1'b0;
    load_s     = 1'b0;
    cnt_next_s = cnt_r;
    if (CALIB && !calib_q_r) begin
      slip_s = 1'b1;
    end else begin
      slip_s = 1'b0;
    end
    if (slip_s) begin
      cnt_next_s = cnt_r;
      load_s     = 1'b0;
    end else begin
      cnt_next_s = cnt_r + 2'd1;
      load_s     = (cnt_r == 2'd3);
    end
  end

  // Serial shift register; shifts on every edge, slip cycles included.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sh_r <= {(WORD_W-1){INIT}};
    end else begin
      sh_r <= {D, sh_r[WORD_W-2:1]};
    end
  end

  // Word-phase counter and CALIB edge-detect history. calib_q resets high so
  // CALIB held through reset does not produce a spurious slip.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_r     <= 2'd0;
      calib_q_r <= 1'b1;
    end else begin
      cnt_r     <= cnt_next_s;
      calib_q_r <= CALIB;
    end
  end

  // Parallel word and VALID strobe; word holds between loads.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      word_r  <= {WORD_W{INIT}};
      valid_r <= 1'b0;
    end else begin
      if (load_s) begin
        word_r <= {D, sh_r};
      end else begin
        word_r <= word_r;
      end
      valid_r <= load_s;
    end
  end

  assign Q0    = word_r[0];
  assign Q1    = word_r[1];
  assign Q2    = word_r[2];
  assign Q3    = word_r[3];
  assign VALID = valid_r;

endmodule

// File: tb/tb_ides4_sc.sv
// Table-driven bench for ides4_sc. Each row optionally pulses RESET
// (checked asynchronously, before any clock edge), then drives D/CALIB for
// one rising edge and compares {Q0,Q1,Q2,Q3} and VALID just after the edge.
module tb_ides4_sc;

  logic clk;
  logic rst;
  logic d;
  logic calib;
  logic q0, q1, q2, q3, valid;

  int total;
  int bad;

  ides4_sc #(.INIT(1'b1)) dut (
    .CLK(clk), .RESET(rst), .D(d), .CALIB(calib),
    .Q0(q0), .Q1(q1), .Q2(q2), .Q3(q3), .VALID(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_before;
    logic       d;
    logic       calib;
    logic [3:0] exp_q;   // {Q0,Q1,Q2,Q3}
    logic       exp_v;
  } vec_t;

  vec_t vecs [0:63];
  int   nvec;

  task automatic add(input logic r, input logic dd, input logic cc,
                     input logic [3:0] q, input logic v);
    vecs[nvec].rst_before = r;
    vecs[nvec].d          = dd;
    vecs[nvec].calib      = cc;
    vecs[nvec].exp_q      = q;
    vecs[nvec].exp_v      = v;
    nvec = nvec + 1;
  endtask

  task automatic check(input string name, input int idx,
                       input logic [3:0] act, input logic [3:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s row=%0d actual=%b required=%b", name, idx, act, exp);
    end
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic reset_pulse(input int idx);
    calib = 1'b0;
    rst = 1'b1;
    #1;
    check("async_reset_q", idx, {q0, q1, q2, q3}, 4'b1111);
    check("async_reset_valid", idx, {3'b000, valid}, 4'b0000);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    nvec  = 0;
    rst   = 1'b0;
    d     = 1'b0;
    calib = 1'b0;

    // Segment A: basic word and continuous stream, then mid-word reset.
    add(1'b1, 1'b1, 1'b0, 4'b1111, 1'b0); // e1
    add(1'b0, 1'b0, 1'b0, 4'b1111, 1'b0); // e2
    add(1'b0, 1'b1, 1'b0, 4'b1111, 1'b0); // e3
    add(1'b0, 1'b1, 1'b0, 4'b1011, 1'b1); // e4 load 1,0,1,1
    add(1'b0, 1'b0, 1'b0, 4'b1011, 1'b0); // e5
    add(1'b0, 1'b0, 1'b0, 4'b1011, 1'b0); // e6
    add(1'b0, 1'b1, 1'b0, 4'b1011, 1'b0); // e7
    add(1'b0, 1'b0, 1'b0, 4'b0010, 1'b1); // e8 load 0,0,1,0
    add(1'b0, 1'b1, 1'b0, 4'b0010, 1'b0); // e9
    add(1'b0, 1'b0, 1'b0, 4'b0010, 1'b0); // e10 (partial word)
    // Mid-word reset: partial word discarded, load on 4th edge after release.
    add(1'b1, 1'b0, 1'b0, 4'b1111, 1'b0); // e1
    add(1'b0, 1'b1, 1'b0, 4'b1111, 1'b0); // e2
    add(1'b0, 1'b0, 1'b0, 4'b1111, 1'b0); // e3
    add(1'b0, 1'b0, 1'b0, 4'b0100, 1'b1); // e4 load 0,1,0,0

    // Segment B: CALIB rises at edge 2 and stays high.
    add(1'b1, 1'b1, 1'b0, 4'b1111, 1'b0); // e1
    add(1'b0, 1'b0, 1'b1, 4'b1111, 1'b0); // e2 slip
    add(1'b0, 1'b1, 1'b1, 4'b1111, 1'b0); // e3
    add(1'b0, 1'b1, 1'b1, 4'b1111, 1'b0); // e4 no load
    add(1'b0, 1'b0, 1'b1, 4'b0110, 1'b1); // e5 load 0,1,1,0
    add(1'b0, 1'b0, 1'b1, 4'b0110, 1'b0); // e6
    add(1'b0, 1'b1, 1'b1, 4'b0110, 1'b0); // e7
    add(1'b0, 1'b1, 1'b1, 4'b0110, 1'b0); // e8
    add(1'b0, 1'b1, 1'b1, 4'b0111, 1'b1); // e9 load
    add(1'b0, 1'b1, 1'b1, 4'b0111, 1'b0); // e10
    add(1'b0, 1'b0, 1'b1, 4'b0111, 1'b0); // e11
    add(1'b0, 1'b0, 1'b1, 4'b0111, 1'b0); // e12
    add(1'b0, 1'b1, 1'b1, 4'b1001, 1'b1); // e13 load

    // Segment C: slip exactly at the load edge, then back-to-back slips.
    add(1'b1, 1'b1, 1'b0, 4'b1111, 1'b0); // e1
    add(1'b0, 1'b1, 1'b0, 4'b1111, 1'b0); // e2
    add(1'b0, 1'b0, 1'b0, 4'b1111, 1'b0); // e3
    add(1'b0, 1'b0, 1'b1, 4'b1111, 1'b0); // e4 slip at cnt 3, no load
    add(1'b0, 1'b1, 1'b0, 4'b1001, 1'b1); // e5 load, Q3 = D of e5
    add(1'b0, 1'b0, 1'b1, 4'b1001, 1'b0); // e6 slip
    add(1'b0, 1'b1, 1'b0, 4'b1001, 1'b0); // e7
    add(1'b0, 1'b0, 1'b1, 4'b1001, 1'b0); // e8 slip
    add(1'b0, 1'b1, 1'b0, 4'b1001, 1'b0); // e9 (would load without slips)
    add(1'b0, 1'b1, 1'b0, 4'b1001, 1'b0); // e10
    add(1'b0, 1'b0, 1'b0, 4'b0110, 1'b1); // e11 load 0,1,1,0
    add(1'b0, 1'b1, 1'b0, 4'b0110, 1'b0); // e12

    // Reach a point just after a rising edge before applying rows.
    @(posedge clk);
    #1;
    for (int i = 0; i < nvec; i++) begin
      if (vecs[i].rst_before) begin
        reset_pulse(i);
      end
      d     = vecs[i].d;
      calib = vecs[i].calib;
      @(posedge clk);
      #1;
      check("word_q", i, {q0, q1, q2, q3}, vecs[i].exp_q);
      check("valid", i, {3'b000, valid}, {3'b000, vecs[i].exp_v});
    end

    // CALIB held high through reset must not slip: load still on edge 4.
    calib = 1'b1;
    rst   = 1'b1;
    #1;
    rst   = 1'b0;
    #1;
    for (int e = 1; e <= 4; e++) begin
      d = e[0];
      @(posedge clk);
      #1;
      check("calib_thru_reset_valid", e, {3'b000, valid},
            {3'b000, (e == 4) ? 1'b1 : 1'b0});
    end
    check("calib_thru_reset_q", 4, {q0, q1, q2, q3}, 4'b1010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout reached actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
